// File: rtl/alu_seq_if.sv
// Operation/result bundle for the sequential EX-stage ALU.
// The master drives operations and sees results; the slave is the ALU itself.
interface alu_seq_if #(
    parameter int WIDTH = 32
);
    logic             flush_i;
    logic             valid_i;
    logic             ready_o;
    logic [2:0]       ALUCtrl_i;
    logic [WIDTH-1:0] data1_i;
    logic [WIDTH-1:0] data2_i;
    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic [WIDTH-1:0] hi_o;
    logic             Zero_o;
    logic             err_o;

    modport master (
        output flush_i,
        output valid_i,
        output ALUCtrl_i,
        output data1_i,
        output data2_i,
        input  ready_o,
        input  valid_o,
        input  data_o,
        input  hi_o,
        input  Zero_o,
        input  err_o
    );

    modport slave (
        input  flush_i,
        input  valid_i,
        input  ALUCtrl_i,
        input  data1_i,
        input  data2_i,
        output ready_o,
        output valid_o,
        output data_o,
        output hi_o,
        output Zero_o,
        output err_o
    );
endinterface

// File: rtl/alu_seq_unit.sv
// Registered WIDTH-bit ALU: single-cycle logic/arith ops plus an
// iterative shift-add unsigned multiply producing a 2*WIDTH-bit product.
module alu_seq_unit #(
    parameter int WIDTH = 32
) (
    input  logic      clk_i,
    input  logic      rst_i,
    alu_seq_if.slave  bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_XOR = 3'b011;
    localparam logic [2:0] OP_MUL = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MULT,
        S_DONE
    } state_e;

    state_e             state_q;
    logic [CW-1:0]      cnt_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   data_q;
    logic [WIDTH-1:0]   hi_q;
    logic               valid_q;
    logic               zero_q;
    logic               err_q;

    logic [WIDTH-1:0]   res_d;
    logic               res_err_d;
    logic               slt_d;
    logic [2*WIDTH-1:0] step_d;

    assign slt_d = $signed(bus.data1_i) < $signed(bus.data2_i);

    always_comb begin
        res_d     = '0;
        res_err_d = 1'b0;
        unique case (bus.ALUCtrl_i)
            OP_AND:  res_d = bus.data1_i & bus.data2_i;
            OP_OR:   res_d = bus.data1_i | bus.data2_i;
            OP_ADD:  res_d = bus.data1_i + bus.data2_i;
            OP_XOR:  res_d = bus.data1_i ^ bus.data2_i;
            OP_SUB:  res_d = bus.data1_i - bus.data2_i;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, slt_d};
            OP_MUL:  res_d = '0;
            default: res_err_d = 1'b1;
        endcase
    end

    // One shift-add step: add the shifted multiplicand when multiplier bit 0 is set
    assign step_d = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            data_q   <= '0;
            hi_q     <= '0;
            valid_q  <= 1'b0;
            zero_q   <= 1'b1;
            err_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.flush_i) begin
                state_q <= S_IDLE;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        if (bus.valid_i) begin
                            if (bus.ALUCtrl_i == OP_MUL) begin
                                state_q  <= S_MULT;
                                acc_q    <= '0;
                                mcand_q  <= {{WIDTH{1'b0}}, bus.data1_i};
                                mplier_q <= bus.data2_i;
                                cnt_q    <= CW'(WIDTH - 1);
                            end else begin
                                state_q <= S_DONE;
                                valid_q <= 1'b1;
                                data_q  <= res_d;
                                hi_q    <= '0;
                                zero_q  <= (res_d == '0);
                                err_q   <= res_err_d;
                            end
                        end
                    end
                    S_MULT: begin
                        acc_q    <= step_d;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        if (cnt_q == '0) begin
                            state_q         <= S_DONE;
                            valid_q         <= 1'b1;
                            {hi_q, data_q}  <= step_d;
                            zero_q          <= (step_d == '0);
                            err_q           <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    S_DONE: state_q <= S_IDLE;
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign bus.ready_o = (state_q == S_IDLE);
    assign bus.valid_o = valid_q;
    assign bus.data_o  = data_q;
    assign bus.hi_o    = hi_q;
    assign bus.Zero_o  = zero_q;
    assign bus.err_o   = err_q;

endmodule

// File: doc/alu_seq_unit.md
# alu_seq_unit

Parametrised, registered successor to the combinational ALU control/ALU pair: a WIDTH-bit ALU that accepts one operation at a time through a valid/ready handshake. It executes logic/arithmetic ops in one cycle and unsigned multiply as an iterative shift-add over WIDTH cycles with a full 2·WIDTH-bit product. It sits in the EX stage, and the pipeline stalls on `ready_o`. The op encoding extends the existing 3-bit ALUCtrl codes.

## Interface
- `WIDTH`, default 32: operand and result width. Legal values are 4 to 64.
- `clk_i`, in, 1: single clock. All state changes on the rising edge.
- `rst_i`, in, 1: asynchronous, active-high reset.
- `flush_i`, in, 1: synchronous abort of any in-flight operation.
- `valid_i`, in, 1: an operation is presented.
- `ready_o`, out, 1: unit is idle and can accept an operation.
- `ALUCtrl_i`, in, 3: op code.
  - And = 000, Or = 001, Add = 010, Xor = 011 (new), Mult = 100, Subtract = 110, Slt = 111 (new).
  - 101 is illegal.
- `data1_i`, in, WIDTH: operand A.
- `data2_i`, in, WIDTH: operand B.
- `valid_o`, out, 1: one-cycle pulse marking a new result.
- `data_o`, out, WIDTH: result, or the low half of the product.
- `hi_o`, out, WIDTH: high half of the product. 0 for non-Mult ops.
- `Zero_o`, out, 1: the full result ({hi_o, data_o}) equals 0.
- `err_o`, out, 1: the last result came from an illegal op code.

## Operation
- **States:**
  - IDLE: `ready_o` = 1.
  - MULT: iterating.
  - DONE: one cycle, `valid_o` = 1.
- **Acceptance:** an op is accepted on a rising edge where the state is IDLE, `valid_i` = 1 and `flush_i` = 0.
  - Operands and op code are captured at acceptance. Later input changes are ignored.
  - `valid_i` outside IDLE is ignored. It is not queued.
- **Single-cycle ops** (And, Or, Add, Xor, Subtract, Slt, illegal): the result is registered at the acceptance edge, and the state goes IDLE→DONE.
  - Add and Subtract wrap modulo 2^WIDTH. No carry or overflow output.
  - Slt: `data_o` = 1 if signed(A) < signed(B), else 0.
  - `hi_o` = 0 for all single-cycle ops.
  - Illegal code 101: `data_o` = 0, `hi_o` = 0, `err_o` = 1. `valid_o` still pulses.
- **Mult:** unsigned A×B.
  - At acceptance the state goes IDLE→MULT. Accumulator is cleared, multiplicand and multiplier are loaded, and the counter is set to WIDTH−1.
  - Each MULT cycle performs one shift-add step on bit 0 of the multiplier.
  - When the counter = 0, the final product is written to {`hi_o`, `data_o`} and the state goes to DONE. Otherwise the counter decrements.
  - `hi_o`/`data_o` are not updated during iteration. They hold the previous result.
- **DONE → IDLE** unconditionally.
- `data_o`, `hi_o`, `Zero_o` and `err_o` update only together with `valid_o`. They hold their values until the next result.
- **flush_i** = 1 at any edge: state goes to IDLE, and `valid_o` is 0 at that edge.
  - Outputs hold their previous values. No acceptance occurs on that edge.
  - Flush wins over `valid_i` and over multiply completion.
- **rst_i** asserted, including mid-operation: immediately resets state to IDLE and the counter to 0.
  - `ready_o` = 1.
  - `valid_o`, `data_o`, `hi_o` and `err_o` = 0.
  - `Zero_o` = 1, consistent with a zero result.

## Timing
- **Single-cycle op:** accepted at edge k, `valid_o` high in the cycle after edge k, `ready_o` high again after edge k+1. Throughput is 1 op per 2 cycles.
- **Mult:** accepted at edge k, product written and `valid_o` high after edge k+WIDTH, `ready_o` high after edge k+WIDTH+1.
- `ready_o` is combinational from state only. It has no path from `valid_i`.
- `valid_o` is never high for more than one consecutive cycle.
- There is no output back-pressure. The consumer must capture the result during the `valid_o` cycle.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-Mult (WIDTH=8, 0xFF×0xFF, cycle 3).
  - Outputs go to reset values at once, with no clock edge: `ready_o`=1, `valid_o`=0, `data_o`=0, `hi_o`=0, `err_o`=0, `Zero_o`=1.
  - No `valid_o` appears afterwards.
- **Single-cycle ops** (WIDTH=8):
  - Add 0xF0+0x20 → `data_o`=0x10, `Zero_o`=0.
  - Subtract 0x05−0x05 → 0x00, `Zero_o`=1.
  - Slt 0x80,0x01 → 0x01.
  - Xor 0xAA,0x0F → 0xA5.
  - Each gives `valid_o` exactly 1 cycle after acceptance.
- **Mult** (WIDTH=8): 0xFF×0xFF → `hi_o`=0xFE, `data_o`=0x01, `valid_o` exactly 8 cycles after acceptance. 0x00×0x37 → `Zero_o`=1.
- **Busy and illegal ops:**
  - Toggle `valid_i` with new operands during MULT → ignored. The result matches the originally captured operands.
  - `ALUCtrl_i`=101 → `err_o`=1, `data_o`=0, `valid_o` pulses.
- **Flush:**
  - `flush_i` on the final MULT cycle → no `valid_o`, previous outputs retained, `ready_o`=1 next cycle.
  - `flush_i` and `valid_i` together in IDLE → the op is not accepted.
- **Back-to-back:** hold `valid_i` high with 4 Adds.
  - Accepts alternate edges.
  - Exactly 4 `valid_o` pulses with the correct values in order.
